// File: rtl/pipelined_cs_adder.sv
// Two-stage carry-select adder/subtractor with valid/ready flow control.
// Stage 1 forms per-slice conditional sums; stage 2 picks them along the carry chain. Latency 2.
module pipelined_cs_adder #(
  parameter int WIDTH = 16,
  parameter int BLOCK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int NB = WIDTH / BLOCK;

  logic                        s1_adv, s2_adv;
  logic [WIDTH-1:0]            b_eff;
  logic                        c_eff;

  logic [NB-1:0][BLOCK-1:0]    cs0_d, cs1_d, cs0_q, cs1_q;
  logic [NB-1:0]               cc0_d, cc1_d, cc0_q, cc1_q;
  logic                        cin_q, amsb_q, bmsb_q, s1_valid_q;

  logic [WIDTH-1:0]            sum_d, sum_q;
  logic                        cout_d, cout_q, ovf_d, ovf_q, out_valid_q;
  logic                        chain_c;

  assign s2_adv   = !out_valid_q || out_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign in_ready = s1_adv;

  // Subtraction is A + ~B + !cin, so the borrow-in becomes an inverted carry-in.
  assign b_eff = sub ? ~B : B;
  assign c_eff = cin ^ sub;

  always_comb begin
    cs0_d = '0;
    cs1_d = '0;
    cc0_d = '0;
    cc1_d = '0;
    for (int i = 0; i < NB; i++) begin
      {cc0_d[i], cs0_d[i]} = {1'b0, A[i*BLOCK +: BLOCK]} + {1'b0, b_eff[i*BLOCK +: BLOCK]};
      {cc1_d[i], cs1_d[i]} = {1'b0, A[i*BLOCK +: BLOCK]} + {1'b0, b_eff[i*BLOCK +: BLOCK]}
                             + {{BLOCK{1'b0}}, 1'b1};
    end
  end

  // Carry resolution is a pure mux chain over the precomputed slice results.
  always_comb begin
    sum_d   = '0;
    chain_c = cin_q;
    for (int i = 0; i < NB; i++) begin
      sum_d[i*BLOCK +: BLOCK] = chain_c ? cs1_q[i] : cs0_q[i];
      chain_c                 = chain_c ? cc1_q[i] : cc0_q[i];
    end
    cout_d = chain_c;
    ovf_d  = (amsb_q == bmsb_q) && (sum_d[WIDTH-1] != amsb_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      cs0_q       <= '0;
      cs1_q       <= '0;
      cc0_q       <= '0;
      cc1_q       <= '0;
      cin_q       <= 1'b0;
      amsb_q      <= 1'b0;
      bmsb_q      <= 1'b0;
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      if (s1_adv) begin
        s1_valid_q <= in_valid;
        if (in_valid) begin
          cs0_q  <= cs0_d;
          cs1_q  <= cs1_d;
          cc0_q  <= cc0_d;
          cc1_q  <= cc1_d;
          cin_q  <= c_eff;
          amsb_q <= A[WIDTH-1];
          bmsb_q <= b_eff[WIDTH-1];
        end
      end
      if (s2_adv) begin
        out_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          sum_q  <= sum_d;
          cout_q <= cout_d;
          ovf_q  <= ovf_d;
        end
      end
    end
  end

  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
endmodule

// File: tb/tb_pipelined_cs_adder.sv
// Bench for pipelined_cs_adder: directed cases on 16/4, then random traffic on 8/2, 16/4 and 32/8
// checked against an arithmetic model with per-instance in-order scoreboards.
module tb_pipelined_cs_adder;
  typedef logic [33:0] res_t;  // {ovf, cout, sum zero-extended to 32}

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [2:0]  iv = '0, ordy = 3'b111, cn = '0, sb = '0;
  logic [31:0] a_r [3];
  logic [31:0] b_r [3];
  logic [2:0]  ir, ov, co, of;
  logic [7:0]  s8;
  logic [15:0] s16;
  logic [31:0] s32;

  int   errors = 0;
  int   checks = 0;
  res_t sbq [3][$];
  int   acc [3];
  int   got [3];

  always #5 clk = ~clk;

  pipelined_cs_adder #(.WIDTH(8), .BLOCK(2)) u8 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .A(a_r[0][7:0]), .B(b_r[0][7:0]),
    .cin(cn[0]), .sub(sb[0]), .out_valid(ov[0]), .out_ready(ordy[0]), .sum(s8), .cout(co[0]), .ovf(of[0]));
  pipelined_cs_adder #(.WIDTH(16), .BLOCK(4)) u16 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .A(a_r[1][15:0]), .B(b_r[1][15:0]),
    .cin(cn[1]), .sub(sb[1]), .out_valid(ov[1]), .out_ready(ordy[1]), .sum(s16), .cout(co[1]), .ovf(of[1]));
  pipelined_cs_adder #(.WIDTH(32), .BLOCK(8)) u32 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .A(a_r[2]), .B(b_r[2]),
    .cin(cn[2]), .sub(sb[2]), .out_valid(ov[2]), .out_ready(ordy[2]), .sum(s32), .cout(co[2]), .ovf(of[2]));

  task automatic check(input string tag, input logic [33:0] observed, input logic [33:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic int width_of(input int k);
    return (k == 0) ? 8 : (k == 1) ? 16 : 32;
  endfunction

  function automatic res_t observed(input int k);
    case (k)
      0:       return {of[0], co[0], 24'h0, s8};
      1:       return {of[1], co[1], 16'h0, s16};
      default: return {of[2], co[2], s32};
    endcase
  endfunction

  // Reference: plain integer arithmetic; overflow means the true signed result leaves the W-bit range.
  function automatic res_t model(input int w, input logic [31:0] a, input logic [31:0] b,
                                 input logic c, input logic s);
    longint unsigned mask, av, bv, full;
    longint          as, bs, tr, lim;
    logic [31:0]     sv;
    mask = (64'd1 << w) - 1;
    av   = {32'h0, a} & mask;
    bv   = {32'h0, b} & mask;
    full = s ? av + (~bv & mask) + {63'h0, !c} : av + bv + {63'h0, c};
    lim  = longint'(64'd1 << (w - 1));
    as   = (av >= 64'(lim)) ? longint'(av) - 2 * lim : longint'(av);
    bs   = (bv >= 64'(lim)) ? longint'(bv) - 2 * lim : longint'(bv);
    tr   = s ? as - bs - longint'({63'h0, c}) : as + bs + longint'({63'h0, c});
    sv   = 32'(full & mask);
    return {(tr > lim - 1) || (tr < -lim), full[w], sv};
  endfunction

  task automatic drv(input logic v, input logic [15:0] a, input logic [15:0] b,
                     input logic c, input logic s);
    iv[1] = v; a_r[1] = {16'h0, a}; b_r[1] = {16'h0, b}; cn[1] = c; sb[1] = s;
  endtask

  // Single transaction with out_ready held high: visible the cycle after the stage-1 cycle.
  task automatic send1(input string tag, input logic [15:0] a, input logic [15:0] b, input logic c,
                       input logic s, input logic [15:0] es, input logic ec, input logic eo);
    @(negedge clk); drv(1'b1, a, b, c, s); ordy[1] = 1'b1; #1;
    check({tag, "_in_ready"}, {33'h0, ir[1]}, 34'h1);
    @(negedge clk); drv(1'b0, 16'h0, 16'h0, 1'b0, 1'b0); #1;
    check({tag, "_not_yet"}, {33'h0, ov[1]}, 34'h0);
    @(negedge clk); #1;
    check({tag, "_valid"}, {33'h0, ov[1]}, 34'h1);
    check({tag, "_result"}, observed(1), {eo, ec, 16'h0, es});
  endtask

  task automatic rnd_cycle(input int n);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      iv[k]   = (acc[k] < n) && ($urandom_range(0, 3) != 0);
      ordy[k] = ($urandom_range(0, 3) != 0);
      a_r[k]  = $urandom;
      b_r[k]  = $urandom;
      cn[k]   = 1'($urandom_range(0, 1));
      sb[k]   = 1'($urandom_range(0, 1));
    end
    #1;
    for (int k = 0; k < 3; k++) begin
      // Two-slot pipeline: room exists unless both slots hold data and the consumer stalls.
      check($sformatf("rnd%0d_in_ready", k), {33'h0, ir[k]}, {33'h0, (sbq[k].size() < 2) || ordy[k]});
      if (sbq[k].size() == 0) begin
        check($sformatf("rnd%0d_spurious", k), {33'h0, ov[k]}, 34'h0);
      end else if (ov[k]) begin
        check($sformatf("rnd%0d_result", k), observed(k), sbq[k][0]);
        if (ordy[k]) begin
          void'(sbq[k].pop_front());
          got[k]++;
        end
      end
      if (iv[k] && ir[k]) begin
        sbq[k].push_back(model(width_of(k), a_r[k], b_r[k], cn[k], sb[k]));
        acc[k]++;
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      a_r[k] = '0; b_r[k] = '0; acc[k] = 0; got[k] = 0;
    end
    #1 rst = 1'b1;
    #2;
    check("reset_out_valid", {33'h0, ov[1]}, 34'h0);
    check("reset_in_ready", {33'h0, ir[1]}, 34'h1);
    check("reset_outputs", observed(1), 34'h0);
    @(negedge clk); rst = 1'b0; #1;
    check("post_reset_in_ready", {33'h0, ir[1]}, 34'h1);

    send1("add", 16'h0aa0, 16'h0ff2, 1'b0, 1'b0, 16'h1a92, 1'b0, 1'b0);
    send1("add_wrap", 16'hfb10, 16'h13f2, 1'b1, 1'b0, 16'h0f03, 1'b1, 1'b0);
    send1("add_ovf", 16'h7fff, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    send1("sub", 16'h0400, 16'h00f2, 1'b0, 1'b1, 16'h030e, 1'b1, 1'b0);
    send1("sub_borrow", 16'h0000, 16'h0001, 1'b0, 1'b1, 16'hffff, 1'b0, 1'b0);

    // Back-pressure: consumer stalls for four edges while three operands are offered.
    @(negedge clk); ordy[1] = 1'b0; drv(1'b1, 16'h671f, 16'h1234, 1'b1, 1'b0); #1;
    check("bp_accept1", {33'h0, ir[1]}, 34'h1);
    @(negedge clk); drv(1'b1, 16'hbb00, 16'h0cf2, 1'b1, 1'b0); #1;
    check("bp_accept2", {33'h0, ir[1]}, 34'h1);
    @(negedge clk); drv(1'b1, 16'hbb00, 16'hcff2, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      check("bp_full", {33'h0, ir[1]}, 34'h0);
      check("bp_hold_valid", {33'h0, ov[1]}, 34'h1);
      check("bp_hold", observed(1), {2'b00, 16'h0, 16'h7954});
    end
    @(negedge clk); ordy[1] = 1'b1; #1;
    check("bp_release_in_ready", {33'h0, ir[1]}, 34'h1);
    check("bp_out1", observed(1), {2'b00, 16'h0, 16'h7954});
    @(negedge clk); drv(1'b0, 16'h0, 16'h0, 1'b0, 1'b0); #1;
    check("bp_out2", observed(1), {2'b00, 16'h0, 16'hc7f3});
    @(negedge clk); #1;
    check("bp_out3", observed(1), {2'b01, 16'h0, 16'h8af3});
    @(negedge clk); #1;
    check("bp_drained", {33'h0, ov[1]}, 34'h0);

    // Asynchronous reset with two transactions in flight.
    @(negedge clk); ordy[1] = 1'b0; drv(1'b1, 16'h1111, 16'h2222, 1'b0, 1'b0);
    @(negedge clk); drv(1'b1, 16'h3333, 16'h4444, 1'b0, 1'b0);
    @(negedge clk); drv(1'b1, 16'h5555, 16'h6666, 1'b0, 1'b0); #1;
    check("rst_pre_valid", {33'h0, ov[1]}, 34'h1);
    #1 rst = 1'b1; #1;
    check("rst_async_valid", {33'h0, ov[1]}, 34'h0);
    check("rst_async_in_ready", {33'h0, ir[1]}, 34'h1);
    check("rst_async_outputs", observed(1), 34'h0);
    @(negedge clk); rst = 1'b0; ordy[1] = 1'b1; drv(1'b0, 16'h0, 16'h0, 1'b0, 1'b0); #1;
    check("rst_release_in_ready", {33'h0, ir[1]}, 34'h1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      check("rst_no_stale", {33'h0, ov[1]}, 34'h0);
    end

    // Random traffic on all three geometries.
    begin
      int cyc = 0;
      while ((got[0] < 1000 || got[1] < 1000 || got[2] < 1000) && cyc < 30000) begin
        rnd_cycle(1000);
        cyc++;
      end
    end
    for (int k = 0; k < 3; k++) begin
      check($sformatf("rnd%0d_accepted", k), 34'(acc[k]), 34'd1000);
      check($sformatf("rnd%0d_delivered", k), 34'(got[k]), 34'd1000);
      check($sformatf("rnd%0d_leftover", k), 34'(sbq[k].size()), 34'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
